// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and widths for the register-file write arbiter and its AUX buffer.
package regfile_write_arbiter_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int XLEN      = 32;

    typedef struct packed {
        logic                 valid;
        logic                 dead;
        logic [RF_ADDR_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } aux_entry_t;

endpackage

// File: rtl/regfile_write_arbiter_aux_wb_fifo.sv
// In-order buffer of pending AUX results, with WAW kill-by-rd and a youngest-match query.
// Latency: push and pop take effect at the rising edge; the head and query outputs are combinational.
// Backpressure: the parent must not push when count == DEPTH or pop when count == 0.
module aux_wb_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int N     = RF_ADDR_W,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_vld,
    input  logic [N-1:0]             push_rd,
    input  logic [XLEN-1:0]          push_dat,
    input  logic                     pop,
    input  logic                     kill_vld,
    input  logic [N-1:0]             kill_rd,
    input  logic [N-1:0]             q_rd,
    output logic                     q_hit,
    output logic [XLEN-1:0]          q_dat,
    output logic                     head_live,
    output logic [N-1:0]             head_rd,
    output logic [XLEN-1:0]          head_dat,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    aux_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] q_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // A younger WB write to the same rd makes the buffered value obsolete.
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_vld && mem[i].valid && N'(mem[i].rd) == kill_rd) begin
                    mem[i].dead <= 1'b1;
                end
            end
            if (pop) begin
                mem[head].valid <= 1'b0;
                mem[head].dead  <= 1'b0;
                head            <= head + 1'b1;
            end
            if (push_vld) begin
                mem[tail] <= '{valid: 1'b1,
                               dead:  kill_vld && (push_rd == kill_rd),
                               rd:    RF_ADDR_W'(push_rd),
                               data:  push_dat};
                tail      <= tail + 1'b1;
            end
            count <= count + CNT_W'(push_vld) - CNT_W'(pop);
        end
    end

    assign head_live = mem[head].valid & ~mem[head].dead;
    assign head_rd   = N'(mem[head].rd);
    assign head_dat  = mem[head].data;

    // Walk oldest to youngest so the last match found is the youngest one.
    always_comb begin
        q_hit = 1'b0;
        q_dat = '0;
        q_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            q_idx = head + PTR_W'(k);
            if (mem[q_idx].valid && !mem[q_idx].dead &&
                N'(mem[q_idx].rd) == q_rd && q_rd != '0) begin
                q_hit = 1'b1;
                q_dat = mem[q_idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between pipeline WB (priority) and a buffered AUX producer.
// Latency: one cycle from request to rf_* outputs; the register file commits on the falling edge.
// Backpressure: aux_ready drops when the buffer is full; wb_stall asks WB to yield after starvation.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int N            = RF_ADDR_W,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_we,
    input  logic [N-1:0]           wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    input  logic                   aux_valid,
    output logic                   aux_ready,
    input  logic [N-1:0]           aux_rd,
    input  logic [XLEN-1:0]        aux_data,
    input  logic [N-1:0]           q_rd,
    output logic                   q_hit,
    output logic [XLEN-1:0]        q_data,
    output logic                   wb_stall,
    output logic                   rf_we,
    output logic [N-1:0]           rf_waddr,
    output logic [XLEN-1:0]        rf_wdata,
    output logic [$clog2(DEPTH):0] aux_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1) + 1;

    logic            wb_wr;
    logic            push_vld;
    logic            pop;
    logic            fifo_empty;
    logic            head_live;
    logic [N-1:0]    head_rd;
    logic [XLEN-1:0] head_dat;
    logic [ST_W-1:0] starve_cnt;
    logic [ST_W-1:0] starve_nxt;

    assign wb_wr      = wb_we && (wb_rd != '0);
    assign fifo_empty = (aux_count == '0);
    assign aux_ready  = ~rst && (aux_count != CNT_W'(DEPTH));
    // x0 results are accepted but never occupy a slot.
    assign push_vld   = aux_valid && aux_ready && (aux_rd != '0);
    assign pop        = ~wb_wr && ~fifo_empty;

    aux_wb_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_vld  (push_vld),
        .push_rd   (aux_rd),
        .push_dat  (aux_data),
        .pop       (pop),
        .kill_vld  (wb_wr),
        .kill_rd   (wb_rd),
        .q_rd      (q_rd),
        .q_hit     (q_hit),
        .q_dat     (q_data),
        .head_live (head_live),
        .head_rd   (head_rd),
        .head_dat  (head_dat),
        .count     (aux_count)
    );

    always_comb begin
        starve_nxt = starve_cnt;
        if (fifo_empty || pop) begin
            starve_nxt = '0;
        end else if (starve_cnt != '1) begin
            starve_nxt = starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            starve_cnt <= '0;
            wb_stall   <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            wb_stall   <= (starve_nxt >= ST_W'(STARVE_LIMIT));
            if (wb_wr) begin
                rf_we    <= 1'b1;
                rf_waddr <= wb_rd;
                rf_wdata <= wb_data;
            end else if (pop) begin
                // A killed head just frees its slot; address and data hold.
                rf_we <= head_live;
                if (head_live) begin
                    rf_waddr <= head_rd;
                    rf_wdata <= head_dat;
                end
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed vector table for the scenarios of interest, then randomized traffic against a queue model.
module tb_regfile_write_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
    localparam int NV    = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_rd;
    logic [31:0] aux_data;
    logic [4:0]  q_rd;
    logic        q_hit;
    logic [31:0] q_data;
    logic        wb_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  aux_count;

    int n_run  = 0;
    int n_fail = 0;

    logic [31:0] rf_m [32];

    regfile_write_arbiter #(.N(5), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .aux_valid (aux_valid),
        .aux_ready (aux_ready),
        .aux_rd    (aux_rd),
        .aux_data  (aux_data),
        .q_rd      (q_rd),
        .q_hit     (q_hit),
        .q_data    (q_data),
        .wb_stall  (wb_stall),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .aux_count (aux_count)
    );

    always #5 clk = ~clk;

    // Register file itself: commits on the falling edge.
    always @(negedge clk) begin
        if (rf_we === 1'b1) rf_m[rf_waddr] <= rf_wdata;
    end

    typedef struct packed {
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic [4:0]  qrd;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [1:0]  e_cnt;
        logic        e_rdy;
        logic        e_hit;
        logic [31:0] e_qd;
        logic        e_stall;
    } vec_t;

    vec_t tbl [NV];

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        dead;
    } m_ent_t;

    m_ent_t      mq [$];
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_starve;
    logic        m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] we, input logic [31:0] rd, input logic [31:0] wd,
                                input logic [31:0] av, input logic [31:0] ard, input logic [31:0] ad,
                                input logic [31:0] qrd, input logic [31:0] ewe, input logic [31:0] ea,
                                input logic [31:0] ed, input logic [31:0] ec, input logic [31:0] er,
                                input logic [31:0] eh, input logic [31:0] eq, input logic [31:0] es);
        vec_t v;
        v.wb_we = we[0];   v.wb_rd = rd[4:0];   v.wb_data = wd;
        v.av    = av[0];   v.ard   = ard[4:0];  v.adata   = ad;
        v.qrd   = qrd[4:0];
        v.e_we  = ewe[0];  v.e_addr = ea[4:0];  v.e_data  = ed;
        v.e_cnt = ec[1:0]; v.e_rdy  = er[0];    v.e_hit   = eh[0];
        v.e_qd  = eq;      v.e_stall = es[0];
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        wb_we = v.wb_we; wb_rd = v.wb_rd; wb_data = v.wb_data;
        aux_valid = v.av; aux_rd = v.ard; aux_data = v.adata; q_rd = v.qrd;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("vec%0d rf_we", idx),     32'(rf_we),     32'(v.e_we));
        chk($sformatf("vec%0d rf_waddr", idx),  32'(rf_waddr),  32'(v.e_addr));
        chk($sformatf("vec%0d rf_wdata", idx),  rf_wdata,       v.e_data);
        chk($sformatf("vec%0d aux_count", idx), 32'(aux_count), 32'(v.e_cnt));
        chk($sformatf("vec%0d aux_ready", idx), 32'(aux_ready), 32'(v.e_rdy));
        chk($sformatf("vec%0d q_hit", idx),     32'(q_hit),     32'(v.e_hit));
        chk($sformatf("vec%0d q_data", idx),    q_data,         v.e_qd);
        chk($sformatf("vec%0d wb_stall", idx),  32'(wb_stall),  32'(v.e_stall));
    endtask

    task automatic model_query(input logic [4:0] qr, output logic hit, output logic [31:0] dat);
        hit = 1'b0;
        dat = '0;
        foreach (mq[i]) begin
            if (!mq[i].dead && mq[i].rd == qr && qr != 5'd0) begin
                hit = 1'b1;
                dat = mq[i].data;
            end
        end
    endtask

    task automatic model_step();
        logic   wbw;
        logic   rdy;
        logic   had;
        logic   popped;
        m_ent_t h;
        wbw    = wb_we && wb_rd != 5'd0;
        rdy    = mq.size() < DEPTH;
        had    = mq.size() != 0;
        popped = 1'b0;
        if (wbw) begin
            m_we = 1'b1; m_addr = wb_rd; m_data = wb_data;
            foreach (mq[i]) begin
                if (mq[i].rd == wb_rd) begin
                    h = mq[i]; h.dead = 1'b1; mq[i] = h;
                end
            end
        end else if (mq.size() != 0) begin
            h = mq.pop_front();
            popped = 1'b1;
            m_we = !h.dead;
            if (!h.dead) begin
                m_addr = h.rd; m_data = h.data;
            end
        end else begin
            m_we = 1'b0;
        end
        if (aux_valid && rdy && aux_rd != 5'd0) begin
            h.rd = aux_rd; h.data = aux_data; h.dead = wbw && (aux_rd == wb_rd);
            mq.push_back(h);
        end
        if (had && !popped) m_starve++;
        else m_starve = 0;
        m_stall = (m_starve >= LIMIT);
    endtask

    initial begin
        logic        eh;
        logic [31:0] ed;
        for (int i = 0; i < 32; i++) rf_m[i] = '0;
        rst = 1'b1; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        aux_valid = 1'b0; aux_rd = '0; aux_data = '0; q_rd = '0;

        #2;
        chk("reset aux_ready", 32'(aux_ready), 32'd0);
        chk("reset aux_count", 32'(aux_count), 32'd0);
        chk("reset rf_we",     32'(rf_we),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release aux_ready", 32'(aux_ready), 32'd1);
        chk("release wb_stall",  32'(wb_stall),  32'd0);
        chk("release q_hit",     32'(q_hit),     32'd0);

        //              we rd wd      av ard ad            qrd  ewe ea  ed            ec er eh eq            es
        tbl[0]  = mk(0, 0, 0,      1, 7,  32'hDEADBEEF, 7,  0,  0,  0,            1, 1, 1, 32'hDEADBEEF, 0);
        tbl[1]  = mk(0, 0, 0,      0, 0,  0,            7,  1,  7,  32'hDEADBEEF, 0, 1, 0, 0,            0);
        tbl[2]  = mk(0, 0, 0,      1, 4,  32'h22,       4,  0,  7,  32'hDEADBEEF, 1, 1, 1, 32'h22,       0);
        tbl[3]  = mk(1, 3, 'h11,   0, 0,  0,            4,  1,  3,  32'h11,       1, 1, 1, 32'h22,       0);
        tbl[4]  = mk(1, 3, 'h11,   0, 0,  0,            4,  1,  3,  32'h11,       1, 1, 1, 32'h22,       0);
        tbl[5]  = mk(1, 3, 'h11,   0, 0,  0,            4,  1,  3,  32'h11,       1, 1, 1, 32'h22,       0);
        tbl[6]  = mk(0, 0, 0,      0, 0,  0,            4,  1,  4,  32'h22,       0, 1, 0, 0,            0);
        tbl[7]  = mk(0, 0, 0,      1, 5,  32'hAA,       5,  0,  4,  32'h22,       1, 1, 1, 32'hAA,       0);
        tbl[8]  = mk(1, 5, 'hBB,   0, 0,  0,            5,  1,  5,  32'hBB,       1, 1, 0, 0,            0);
        tbl[9]  = mk(0, 0, 0,      0, 0,  0,            5,  0,  5,  32'hBB,       0, 1, 0, 0,            0);
        tbl[10] = mk(1, 10, 'h33,  1, 6,  32'h66,       6,  1,  10, 32'h33,       1, 1, 1, 32'h66,       0);
        tbl[11] = mk(1, 10, 'h34,  1, 8,  32'h88,       6,  1,  10, 32'h34,       2, 0, 1, 32'h66,       0);
        tbl[12] = mk(1, 10, 'h35,  1, 9,  32'h99,       8,  1,  10, 32'h35,       2, 0, 1, 32'h88,       0);
        tbl[13] = mk(0, 0, 0,      1, 0,  32'h77,       0,  1,  6,  32'h66,       1, 1, 0, 0,            0);
        tbl[14] = mk(1, 10, 'h36,  1, 0,  32'h77,       8,  1,  10, 32'h36,       1, 1, 1, 32'h88,       0);
        tbl[15] = mk(1, 0, 'h55,   0, 0,  0,            8,  1,  8,  32'h88,       0, 1, 0, 0,            0);
        tbl[16] = mk(1, 0, 'h55,   0, 0,  0,            8,  0,  8,  32'h88,       0, 1, 0, 0,            0);
        tbl[17] = mk(0, 0, 0,      1, 12, 32'hC0,       12, 0,  8,  32'h88,       1, 1, 1, 32'hC0,       0);
        tbl[18] = mk(1, 13, 'hD1,  0, 0,  0,            12, 1,  13, 32'hD1,       1, 1, 1, 32'hC0,       0);
        tbl[19] = mk(1, 13, 'hD2,  0, 0,  0,            12, 1,  13, 32'hD2,       1, 1, 1, 32'hC0,       0);
        tbl[20] = mk(1, 13, 'hD3,  0, 0,  0,            12, 1,  13, 32'hD3,       1, 1, 1, 32'hC0,       0);
        tbl[21] = mk(1, 13, 'hD4,  0, 0,  0,            12, 1,  13, 32'hD4,       1, 1, 1, 32'hC0,       1);
        tbl[22] = mk(1, 13, 'hD5,  0, 0,  0,            12, 1,  13, 32'hD5,       1, 1, 1, 32'hC0,       1);
        tbl[23] = mk(0, 0, 0,      0, 0,  0,            12, 1,  12, 32'hC0,       0, 1, 0, 0,            0);

        for (int i = 0; i < NV; i++) apply(tbl[i], i);

        #1;
        chk("rf x7",  rf_m[7],  32'hDEADBEEF);
        chk("rf x3",  rf_m[3],  32'h11);
        chk("rf x4",  rf_m[4],  32'h22);
        chk("rf x5",  rf_m[5],  32'hBB);
        chk("rf x6",  rf_m[6],  32'h66);
        chk("rf x8",  rf_m[8],  32'h88);
        chk("rf x10", rf_m[10], 32'h36);
        chk("rf x12", rf_m[12], 32'hC0);
        chk("rf x13", rf_m[13], 32'hD5);
        chk("rf x0",  rf_m[0],  32'h0);

        // Reset in the middle of traffic: two entries held behind continuous WB.
        @(negedge clk);
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h44;
        aux_valid = 1'b1; aux_rd = 5'd9; aux_data = 32'h91; q_rd = 5'd9;
        @(posedge clk); @(negedge clk);
        aux_rd = 5'd11; aux_data = 32'h92;
        @(posedge clk); @(negedge clk);
        chk("pre-reset aux_count", 32'(aux_count), 32'd2);
        rst = 1'b1;
        #1;
        chk("midrst aux_count", 32'(aux_count), 32'd0);
        chk("midrst rf_we",     32'(rf_we),     32'd0);
        chk("midrst rf_waddr",  32'(rf_waddr),  32'd0);
        chk("midrst rf_wdata",  rf_wdata,       32'd0);
        chk("midrst q_hit",     32'(q_hit),     32'd0);
        chk("midrst aux_ready", 32'(aux_ready), 32'd0);
        chk("midrst wb_stall",  32'(wb_stall),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; wb_we = 1'b0; aux_valid = 1'b0;
        @(negedge clk);
        chk("postrst aux_count", 32'(aux_count), 32'd0);
        chk("postrst aux_ready", 32'(aux_ready), 32'd1);
        chk("postrst rf_we",     32'(rf_we),     32'd0);

        mq.delete();
        m_we = 1'b0; m_addr = '0; m_data = '0; m_starve = 0; m_stall = 1'b0;
        for (int c = 0; c < 400; c++) begin
            chk($sformatf("rnd%0d rf_we", c),     32'(rf_we),     32'(m_we));
            chk($sformatf("rnd%0d rf_waddr", c),  32'(rf_waddr),  32'(m_addr));
            chk($sformatf("rnd%0d rf_wdata", c),  rf_wdata,       m_data);
            chk($sformatf("rnd%0d aux_count", c), 32'(aux_count), 32'(mq.size()));
            chk($sformatf("rnd%0d wb_stall", c),  32'(wb_stall),  32'(m_stall));
            if (wb_stall) wb_we = ($urandom_range(0, 7) == 0);
            else          wb_we = 1'($urandom_range(0, 1));
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = $urandom();
            aux_valid = 1'($urandom_range(0, 1));
            aux_rd    = 5'($urandom_range(0, 7));
            aux_data  = $urandom();
            q_rd      = 5'($urandom_range(0, 7));
            #1;
            model_query(q_rd, eh, ed);
            chk($sformatf("rnd%0d aux_ready", c), 32'(aux_ready), 32'(mq.size() < DEPTH));
            chk($sformatf("rnd%0d q_hit", c),     32'(q_hit),     32'(eh));
            chk($sformatf("rnd%0d q_data", c),    q_data,         ed);
            model_step();
            @(posedge clk);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between the in-order pipeline writeback (WB) and one auxiliary long-latency producer (AUX), such as a multi-cycle mul/div or a miss-return load.
- WB always has priority. AUX results wait in a small in-order buffer, which can also be queried for forwarding.
- Drives the register file write port from registers updated on the rising edge. The register file commits on the following falling edge of the same cycle.

Parameters:
- N, 5, register address width.
- DEPTH, 2, AUX buffer entries (power of 2, at least 2).
- STARVE_LIMIT, 4, consecutive cycles a non-empty buffer may go without a pop before wb_stall is raised.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_we  in  1  pipeline WB write request.
- wb_rd  in  N  WB destination register.
- wb_data  in  32  WB write data.
- aux_valid  in  1  AUX result valid.
- aux_ready  out  1  buffer can accept an AUX result.
- aux_rd  in  N  AUX destination register.
- aux_data  in  32  AUX write data.
- q_rd  in  N  forwarding query register.
- q_hit  out  1  a live buffered entry targets q_rd.
- q_data  out  32  data of the youngest live matching entry.
- wb_stall  out  1  request to the pipeline to hold WB next cycle.
- rf_we  out  1  register file RegWrite.
- rf_waddr  out  N  register file write address.
- rf_wdata  out  32  register file write data.
- aux_count  out  log2(DEPTH)+1  number of occupied buffer entries.

Behaviour:
- Reset (async, immediate):
  - Buffer emptied; all valid and dead bits cleared.
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - Starve counter=0, wb_stall=0, aux_count=0.
  - aux_ready=0 while rst is high, 1 after release.
  - An AUX result offered while rst is high is lost.
- Buffer structure:
  - Circular FIFO with head and tail pointers.
  - Each entry holds {valid, dead, rd, data}.
  - aux_ready = (aux_count != DEPTH), combinational.
- Push:
  - Occurs when aux_valid && aux_ready at a rising edge.
  - If aux_rd==0, the result is handshaken and discarded; no entry is allocated.
- Write-port selection, evaluated at each rising edge:
  1. If wb_we && wb_rd!=0: rf_we<=1, rf_waddr<=wb_rd, rf_wdata<=wb_data. No pop.
  2. Otherwise, if the buffer is non-empty: pop the head.
     - Live head: rf_we<=1 with the head's rd and data.
     - Dead head: rf_we<=0; the slot is freed with no write.
  3. Otherwise: rf_we<=0, with rf_waddr and rf_wdata held.
- Latency and x0:
  - Request to register file commit is 1 cycle: registered at the rising edge, written at the falling edge.
  - wb_we with wb_rd==0 never asserts rf_we.
- WAW kill:
  - A WB write with wb_rd!=0 sets dead on every live entry whose rd matches wb_rd.
  - An AUX result pushed in the same cycle with aux_rd==wb_rd is stored already dead.
  - Rationale: the WB instruction is younger, so its value must be the one that survives.
- Simultaneous push and pop: both happen in the same edge. aux_count is unchanged.
- Full buffer: aux_ready=0. There is no same-cycle bypass from push into a free slot.
- Starvation:
  - The counter increments each cycle the buffer is non-empty and no pop occurs. It clears on a pop or when the buffer is empty.
  - wb_stall is registered; it is 1 while counter >= STARVE_LIMIT.
  - The pipeline must hold wb_we=0 the cycle after wb_stall=1. That guarantees a pop, which clears the counter, so wb_stall drops the following cycle.
  - If wb_we=1 arrives while wb_stall=1, it is still served (WB keeps priority); the counter keeps rising.
- Forwarding query:
  - Purely combinational over live entries; dead entries never hit.
  - q_rd==0 gives q_hit=0.
  - On no hit, q_data=0.
- Pointer wrap: head and tail wrap modulo DEPTH. aux_count disambiguates full from empty.

Decomposition:
- Shared package holds the entry record typedef {valid, dead, rd[N-1:0], data[31:0]}, plus constants RF_ADDR_W=5 and XLEN=32.
- One natural sub-module, aux_wb_fifo: the circular buffer with push, pop, kill-by-rd and the youngest-match query.
- The top level holds port selection, the starve counter and the rf output registers.

Test Plan:
- Reset mid-operation: push 2 AUX entries, then assert rst for half a cycle → aux_count=0, rf_we=0, rf_waddr=0, q_hit=0 immediately; aux_ready=1 after release.
- Idle AUX: push {rd=7, data=0xDEAD_BEEF} with wb_we=0 → next edge rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF; x7 reads 0xDEADBEEF after that falling edge.
- WB priority: WB {rd=3, 0x11} every cycle for 3 cycles with one AUX entry {rd=4, 0x22} buffered → rf writes x3 three times; x4 is written on the first WB-free cycle.
- WAW kill: buffer {rd=5, 0xAA}, then WB {rd=5, 0xBB} → x5 ends 0xBB; the dead pop produces rf_we=0 that cycle; q_rd=5 gives q_hit=0 after the kill.
- Full and x0: fill DEPTH=2 under continuous WB → aux_ready=0; aux_valid with aux_rd=0 when not full is handshaken, aux_count unchanged, x0 remains 0.
- Starvation: one entry buffered plus continuous wb_we → wb_stall=1 on the 5th cycle; bench drops wb_we → pop occurs, wb_stall returns to 0 one cycle later.
